// File: rtl/quad_sum_peak_window_pkg.sv
// Shared widths, lane encodings and state types for the quad-sum peak window.
package quad_sum_peak_window_pkg;

    localparam int SUM_W  = 13;
    localparam int IDX_W  = 10;
    localparam int CYC_W  = 8;
    localparam int LANE_W = 2;

    typedef logic [SUM_W-1:0]  sum_t;
    typedef logic [LANE_W-1:0] lane_t;
    typedef logic [IDX_W-1:0]  idx_t;

    localparam lane_t LANE_APB = 2'd0;
    localparam lane_t LANE_CPD = 2'd1;
    localparam lane_t LANE_EPF = 2'd2;
    localparam lane_t LANE_GPH = 2'd3;

    typedef enum logic {
        HO_IDLE,
        HO_HOLD
    } ho_state_t;

endpackage

// File: rtl/quad_lane_max.sv
// Combinational 4-to-1 unsigned max; ties resolve to the lowest lane.
module quad_lane_max
    import quad_sum_peak_window_pkg::*;
(
    input  logic [SUM_W-1:0]  lane0,
    input  logic [SUM_W-1:0]  lane1,
    input  logic [SUM_W-1:0]  lane2,
    input  logic [SUM_W-1:0]  lane3,
    output logic [SUM_W-1:0]  max_val,
    output logic [LANE_W-1:0] max_lane
);

    sum_t  lo_val;
    sum_t  hi_val;
    lane_t lo_lane;
    lane_t hi_lane;

    // Strict compares only, so an equal higher lane never wins.
    always_comb begin
        lo_val  = lane0;
        lo_lane = LANE_APB;
        hi_val  = lane2;
        hi_lane = LANE_EPF;
        if (lane1 > lane0) begin
            lo_val  = lane1;
            lo_lane = LANE_CPD;
        end
        if (lane3 > lane2) begin
            hi_val  = lane3;
            hi_lane = LANE_GPH;
        end
        max_val  = lo_val;
        max_lane = lo_lane;
        if (hi_val > lo_val) begin
            max_val  = hi_val;
            max_lane = hi_lane;
        end
    end

endmodule

// File: rtl/quad_sum_peak_window.sv
// Windowed peak finder over four lane sums with a holdoff-gated threshold trigger.
module quad_sum_peak_window
    import quad_sum_peak_window_pkg::*;
#(
    parameter int WINDOW  = 16,
    parameter int HOLDOFF = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              VALID_IN,
    input  logic [SUM_W-1:0]  APB,
    input  logic [SUM_W-1:0]  CPD,
    input  logic [SUM_W-1:0]  EPF,
    input  logic [SUM_W-1:0]  GPH,
    input  logic [SUM_W-1:0]  THRESHOLD,
    output logic [SUM_W-1:0]  PEAK,
    output logic [IDX_W-1:0]  PEAK_IDX,
    output logic              PEAK_VALID,
    output logic              TRIGGER,
    output logic              HOLDOFF_ACTIVE
);

    localparam int CNT_W = $clog2(WINDOW);
    localparam int HO_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    logic [1:0] rst_q;
    logic       rst_int;

    // Async assert, release synchronised to CLK.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) rst_q <= 2'b11;
        else     rst_q <= {rst_q[0], 1'b0};
    end

    assign rst_int = rst_q[1];

    sum_t  lm_val;
    lane_t lm_lane;

    quad_lane_max u_max (
        .lane0    (APB),
        .lane1    (CPD),
        .lane2    (EPF),
        .lane3    (GPH),
        .max_val  (lm_val),
        .max_lane (lm_lane)
    );

    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             s1_valid;
    logic             s1_last;
    sum_t             s1_val;
    lane_t            s1_lane;
    logic [CYC_W-1:0] s1_idx;

    assign cnt_last = (cnt == CNT_W'(WINDOW - 1));

    always_ff @(posedge CLK or posedge rst_int) begin
        if (rst_int) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_val   <= '0;
            s1_lane  <= '0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= VALID_IN;
            if (VALID_IN) begin
                s1_val  <= lm_val;
                s1_lane <= lm_lane;
                s1_idx  <= CYC_W'(cnt);
                s1_last <= cnt_last;
                cnt     <= cnt_last ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    sum_t  run_max;
    idx_t  run_idx;
    logic  take;
    logic  close;
    sum_t  fin_val;
    idx_t  fin_idx;

    // Index 0 restarts the window; otherwise only a strictly larger value wins.
    assign take    = (s1_idx == '0) || (s1_val > run_max);
    assign fin_val = take ? s1_val : run_max;
    assign fin_idx = take ? {s1_idx, s1_lane} : run_idx;
    assign close   = s1_valid && s1_last;

    ho_state_t       ho_state;
    ho_state_t       ho_state_nxt;
    logic [HO_W-1:0] ho_cnt;
    logic [HO_W-1:0] ho_cnt_nxt;
    logic            trig_nxt;

    always_comb begin
        ho_state_nxt = ho_state;
        ho_cnt_nxt   = ho_cnt;
        trig_nxt     = 1'b0;
        if (close) begin
            unique case (ho_state)
                HO_IDLE: begin
                    if (fin_val >= THRESHOLD) begin
                        trig_nxt     = 1'b1;
                        ho_cnt_nxt   = HO_W'(HOLDOFF);
                        ho_state_nxt = (HOLDOFF > 0) ? HO_HOLD : HO_IDLE;
                    end
                end
                HO_HOLD: begin
                    ho_cnt_nxt = ho_cnt - HO_W'(1);
                    if (ho_cnt == HO_W'(1)) ho_state_nxt = HO_IDLE;
                end
                default: ho_state_nxt = HO_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge rst_int) begin
        if (rst_int) begin
            run_max    <= '0;
            run_idx    <= '0;
            PEAK       <= '0;
            PEAK_IDX   <= '0;
            PEAK_VALID <= 1'b0;
            TRIGGER    <= 1'b0;
            ho_state   <= HO_IDLE;
            ho_cnt     <= '0;
        end else begin
            PEAK_VALID <= close;
            TRIGGER    <= trig_nxt;
            ho_state   <= ho_state_nxt;
            ho_cnt     <= ho_cnt_nxt;
            if (s1_valid) begin
                run_max <= fin_val;
                run_idx <= fin_idx;
            end
            if (close) begin
                PEAK     <= fin_val;
                PEAK_IDX <= fin_idx;
            end
        end
    end

    assign HOLDOFF_ACTIVE = (ho_state == HO_HOLD);

endmodule

// File: tb/tb_quad_sum_peak_window.sv
// Directed bench for quad_sum_peak_window: vector table plus gap, holdoff and reset sequences.
module tb_quad_sum_peak_window;

    logic        CLK = 1'b0;
    logic        RST;
    logic        VALID_IN;
    logic [12:0] APB, CPD, EPF, GPH, THRESHOLD;
    logic [12:0] PEAK;
    logic [9:0]  PEAK_IDX;
    logic        PEAK_VALID, TRIGGER, HOLDOFF_ACTIVE;

    quad_sum_peak_window #(.WINDOW(16), .HOLDOFF(2)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .VALID_IN       (VALID_IN),
        .APB            (APB),
        .CPD            (CPD),
        .EPF            (EPF),
        .GPH            (GPH),
        .THRESHOLD      (THRESHOLD),
        .PEAK           (PEAK),
        .PEAK_IDX       (PEAK_IDX),
        .PEAK_VALID     (PEAK_VALID),
        .TRIGGER        (TRIGGER),
        .HOLDOFF_ACTIVE (HOLDOFF_ACTIVE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  m1;
        int          c1;
        logic [12:0] v1;
        logic [3:0]  m2;
        int          c2;
        logic [12:0] v2;
        logic [12:0] thr;
        logic [12:0] pk;
        logic [9:0]  idx;
        logic        trig;
        logic        hoa;
    } vec_t;

    vec_t tbl[7];
    int   n_vec = 0;
    int   n_bad = 0;
    int   pv_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic v, input logic [12:0] l0, input logic [12:0] l1,
                       input logic [12:0] l2, input logic [12:0] l3);
        VALID_IN = v;
        APB = l0;
        CPD = l1;
        EPF = l2;
        GPH = l3;
        @(posedge CLK);
        #1;
        if (PEAK_VALID) pv_seen++;
    endtask

    task automatic idle();
        cyc(1'b0, 13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (3) idle();
    endtask

    task automatic run_window(input logic [3:0] m1, input int c1, input logic [12:0] v1,
                              input logic [3:0] m2, input int c2, input logic [12:0] v2,
                              input bit gaps);
        logic [12:0] lv[4];
        pv_seen = 0;
        for (int i = 0; i < 16; i++) begin
            for (int l = 0; l < 4; l++) begin
                lv[l] = 13'h0;
                if (i == c1 && m1[l]) lv[l] = v1;
                else if (i == c2 && m2[l]) lv[l] = v2;
            end
            cyc(1'b1, lv[0], lv[1], lv[2], lv[3]);
            if (gaps && (i % 2 == 0)) begin
                idle();
                idle();
            end
        end
        chk("pv_early", {31'b0, PEAK_VALID}, 32'd0);
        idle();
        chk("pv_lat2", {31'b0, PEAK_VALID}, 32'd1);
        chk("pv_count", pv_seen, 32'd1);
    endtask

    bit tr_exp[8]  = '{1, 0, 0, 1, 0, 0, 1, 0};
    bit hoa_exp[8] = '{1, 1, 0, 1, 1, 0, 1, 1};

    initial begin
        tbl[0] = '{4'b0010, 5,  13'h123,  4'b0000, -1, 13'h0,
                   13'h1FFF, 13'h123,  10'h015, 1'b0, 1'b0};
        tbl[1] = '{4'b1100, 3,  13'h0FF,  4'b1100, 9,  13'h0FF,
                   13'h1FFF, 13'h0FF,  10'h00E, 1'b0, 1'b0};
        tbl[2] = '{4'b0001, 15, 13'h1FFF, 4'b0000, -1, 13'h0,
                   13'h1FFF, 13'h1FFF, 10'h03C, 1'b1, 1'b1};
        tbl[3] = '{4'b0000, -1, 13'h0,    4'b0000, -1, 13'h0,
                   13'h0,    13'h0,    10'h000, 1'b0, 1'b1};
        tbl[4] = '{4'b1000, 0,  13'h005,  4'b0100, 15, 13'h006,
                   13'h0,    13'h006,  10'h03E, 1'b0, 1'b0};
        tbl[5] = '{4'b1111, 7,  13'h0AA,  4'b0000, -1, 13'h0,
                   13'h0AA,  13'h0AA,  10'h01C, 1'b1, 1'b1};
        tbl[6] = '{4'b0001, 2,  13'h100,  4'b0001, 8,  13'h0FF,
                   13'h1FFF, 13'h100,  10'h008, 1'b0, 1'b1};

        RST = 1'b1;
        VALID_IN = 1'b0;
        {APB, CPD, EPF, GPH} = '0;
        THRESHOLD = 13'h1FFF;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_peak", PEAK, 32'd0);
        chk("rst_idx", PEAK_IDX, 32'd0);
        chk("rst_pv", {31'b0, PEAK_VALID}, 32'd0);
        chk("rst_trig", {31'b0, TRIGGER}, 32'd0);
        chk("rst_hoa", {31'b0, HOLDOFF_ACTIVE}, 32'd0);
        RST = 1'b0;
        repeat (3) idle();

        for (int t = 0; t < 7; t++) begin
            THRESHOLD = tbl[t].thr;
            run_window(tbl[t].m1, tbl[t].c1, tbl[t].v1,
                       tbl[t].m2, tbl[t].c2, tbl[t].v2, 1'b0);
            chk($sformatf("v%0d_peak", t), PEAK, tbl[t].pk);
            chk($sformatf("v%0d_idx", t), PEAK_IDX, tbl[t].idx);
            chk($sformatf("v%0d_trig", t), {31'b0, TRIGGER}, {31'b0, tbl[t].trig});
            chk($sformatf("v%0d_hoa", t), {31'b0, HOLDOFF_ACTIVE}, {31'b0, tbl[t].hoa});
            idle();
            chk($sformatf("v%0d_pulse", t), {31'b0, PEAK_VALID}, 32'd0);
            chk($sformatf("v%0d_hold", t), PEAK, tbl[t].pk);
        end

        // Valid pattern 1,0,0,1 with junk on the stalled cycles.
        THRESHOLD = 13'h1FFF;
        run_window(4'b0010, 5, 13'h123, 4'b0000, -1, 13'h0, 1'b1);
        chk("gap_peak", PEAK, 32'h123);
        chk("gap_idx", PEAK_IDX, 32'h015);

        do_reset();
        THRESHOLD = 13'h100;
        for (int w = 0; w < 8; w++) begin
            run_window(4'b0001, 0, 13'h200, 4'b0000, -1, 13'h0, 1'b0);
            chk($sformatf("ho%0d_peak", w + 1), PEAK, 32'h200);
            chk($sformatf("ho%0d_trig", w + 1), {31'b0, TRIGGER}, {31'b0, tr_exp[w]});
            chk($sformatf("ho%0d_hoa", w + 1), {31'b0, HOLDOFF_ACTIVE},
                {31'b0, hoa_exp[w]});
        end

        // Reset mid-window after a large value the next window must not see.
        THRESHOLD = 13'h1FFF;
        for (int i = 0; i < 8; i++)
            cyc(1'b1, (i == 2) ? 13'h1ABC : 13'h0, 13'h0, 13'h0, 13'h0);
        #3;
        RST = 1'b1;
        #1;
        chk("mrst_peak", PEAK, 32'd0);
        chk("mrst_idx", PEAK_IDX, 32'd0);
        chk("mrst_pv", {31'b0, PEAK_VALID}, 32'd0);
        chk("mrst_trig", {31'b0, TRIGGER}, 32'd0);
        chk("mrst_hoa", {31'b0, HOLDOFF_ACTIVE}, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (3) idle();
        run_window(4'b1000, 4, 13'h050, 4'b0000, -1, 13'h0, 1'b0);
        chk("post_peak", PEAK, 32'h050);
        chk("post_idx", PEAK_IDX, 32'h013);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/quad_sum_peak_window.md
Name: quad_sum_peak_window

Overview:
- Sits directly downstream of the quad 12-bit SIMD adder stage.
- Consumes its four 13-bit lane sums (APB, CPD, EPF, GPH) every valid clock.
- Finds the largest sum over a fixed window of WINDOW valid clocks and reports the peak value and where it occurred.
- Raises a threshold trigger with window-based holdoff, which feeds the trigger-decision logic.

Parameters:
- WINDOW, 16, valid input cycles per window; legal range 2..256.
- HOLDOFF, 4, number of windows after a trigger during which TRIGGER is suppressed; 0 means no holdoff.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- VALID_IN  input  1  the four sums are valid this cycle.
- APB  input  13  lane 0 sum, unsigned; the MSB is the adder carry.
- CPD  input  13  lane 1 sum, unsigned.
- EPF  input  13  lane 2 sum, unsigned.
- GPH  input  13  lane 3 sum, unsigned.
- THRESHOLD  input  13  trigger threshold, unsigned; sampled at window close.
- PEAK  output  13  maximum sum of the last closed window.
- PEAK_IDX  output  10  {cycle index within window [7:0], lane [1:0]}.
- PEAK_VALID  output  1  one-cycle pulse when PEAK and PEAK_IDX update.
- TRIGGER  output  1  one-cycle pulse, coincident with PEAK_VALID.
- HOLDOFF_ACTIVE  output  1  high while the holdoff counter is nonzero.

Behaviour:
- Reset (async assert, sync deassert taken from CLK domain) clears:
  - PEAK, PEAK_IDX, PEAK_VALID, TRIGGER and HOLDOFF_ACTIVE to 0.
  - The window counter, running max, running index, holdoff counter and the stage-1 valid bit.
- Stage 1 (registered, only when VALID_IN=1):
  - Captures the max of the four lanes, its 2-bit lane number and the current cycle index.
  - Ties go to the lowest lane.
  - Captures s1_last = (counter == WINDOW-1).
  - The counter increments on each VALID_IN and wraps to 0 after WINDOW-1.
  - s1_valid <= VALID_IN every clock.
- Stage 2 (when s1_valid=1):
  - If this is the first sample of a window (cycle index 0), running max <= stage-1 value unconditionally.
  - Otherwise running max is replaced only if the stage-1 value is strictly greater. Ties keep the earliest sample.
  - If s1_last: PEAK and PEAK_IDX load the final result, including the current sample, and PEAK_VALID pulses on the next cycle.
- Latency: PEAK_VALID is high exactly 2 CLK cycles after the VALID_IN edge carrying the window's last sample, assuming VALID_IN was continuous. Gaps in VALID_IN delay the window without corrupting it.
- VALID_IN=0 stalls the counter and stage 2. Partial windows persist across gaps of any length.
- TRIGGER rules:
  - TRIGGER = PEAK_VALID && (closing peak >= THRESHOLD) && holdoff counter == 0.
  - On TRIGGER, the holdoff counter loads HOLDOFF.
  - Each later window close with the counter nonzero decrements it, so exactly HOLDOFF window closes are suppressed.
  - A suppressed window still produces PEAK_VALID.
- Saturation: sums are already 13-bit, so there is no arithmetic overflow. The comparison is a full 13-bit unsigned compare; 0x1FFF is a legal peak.
- PEAK_IDX: cycle-index bits above clog2(WINDOW) read 0. With WINDOW=256 the index uses all 8 bits.
- Reset mid-window discards the partial window. The first window after reset starts at index 0.
- THRESHOLD changes mid-window only matter at the close cycle.
- PEAK and PEAK_IDX hold their value between PEAK_VALID pulses.

Decomposition:
- Shared package:
  - Lane sum width (13).
  - Index field width (10).
  - Lane encoding constants LANE_APB=0, LANE_CPD=1, LANE_EPF=2, LANE_GPH=3.
- One sub-module: quad_lane_max. It is the combinational 4-to-1 max with lowest-lane tie-break, returning value and lane, and is reused by any future per-window statistic block.
- Window counter, running max and holdoff FSM stay in the top level.

Test Plan:
- WINDOW=16, continuous VALID_IN, all lanes 0 except CPD=0x123 at cycle 5:
  - PEAK=0x123, PEAK_IDX={5,1}=0x015, PEAK_VALID exactly 2 clocks after the 16th valid.
- Tie test: EPF=GPH=0x0FF at cycle 3 and again at cycle 9:
  - PEAK_IDX=0x00E (cycle 3, lane 2).
- Boundary values: 0x1FFF on lane 0 at cycle 15, the last sample:
  - PEAK=0x1FFF, PEAK_IDX=0x03C.
  - The next window of all zeros yields PEAK=0, PEAK_IDX=0.
- THRESHOLD=0x100, HOLDOFF=2, every window peak 0x200:
  - TRIGGER on windows 1, 4, 7.
  - HOLDOFF_ACTIVE high during windows 2–3 and 5–6.
  - PEAK_VALID on every window.
- VALID_IN toggled 1,0,0,1 pattern across a window:
  - Same PEAK and PEAK_IDX as the continuous case.
  - PEAK_VALID 2 clocks after the 16th valid.
- RST pulsed asynchronously at cycle 8 of a window:
  - All outputs 0 immediately.
  - The next full window of 16 valids closes normally, with no stale peak from before reset.
